// File: rtl/i2c_diag_frame_gen.sv
// Diagnostic frame-event generator for the I2C status/reporting path.
// Emits a periodic one-cycle new_frame strobe with a mode-selected line count,
// holds one event back while the consumer is busy and counts dropped ticks.
module i2c_diag_frame_gen #(
    parameter int unsigned CLK_HZ     = 27000000,
    parameter int unsigned PERIOD_MS  = 500,
    parameter int unsigned LINES_A    = 240,
    parameter int unsigned LINES_B    = 288,
    parameter int unsigned LINES_MIN  = 200,
    parameter int unsigned LINES_MAX  = 320,
    parameter int unsigned LINES_STEP = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic       busy,
    output logic       new_frame,
    output logic [9:0] frame_lines,
    output logic [7:0] frame_id,
    output logic [7:0] overrun_cnt,
    output logic       pending
);

    localparam int unsigned      PERIOD_CYC = (CLK_HZ / 1000) * PERIOD_MS;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD_CYC - 1);

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_ALT    = 2'd1,
        MODE_SWEEP  = 2'd2,
        MODE_SILENT = 2'd3
    } mode_t;

    logic [CNT_W-1:0] cnt;
    mode_t            cur_mode;
    mode_t            last_mode;
    logic             alt_b;
    logic             tick;
    logic             active;
    logic             issue;
    logic             restart;
    logic [10:0]      sweep_sum;
    logic [9:0]       next_lines;

    // Decode tick, issue condition and the value the next event would carry.
    always_comb begin
        cur_mode   = mode_t'(mode);
        tick       = (cnt == CNT_LAST);
        active     = enable && (cur_mode != MODE_SILENT);
        issue      = active && !busy && (tick || pending);
        restart    = (cur_mode != last_mode);
        sweep_sum  = {1'b0, frame_lines} + 11'(LINES_STEP);
        next_lines = 10'(LINES_A);
        case (cur_mode)
            MODE_ALT: begin
                if (!restart && alt_b)
                    next_lines = 10'(LINES_B);
            end
            MODE_SWEEP: begin
                // frame_lines is the previous sweep value whenever no restart occurs
                if (restart || (sweep_sum > 11'(LINES_MAX)))
                    next_lines = 10'(LINES_MIN);
                else
                    next_lines = sweep_sum[9:0];
            end
            default: next_lines = 10'(LINES_A);
        endcase
    end

    // Period counter: runs 0..PERIOD_CYC-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt <= '0;
        else if (!enable || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Event queue, overrun counter and registered event outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            new_frame   <= 1'b0;
            frame_lines <= 10'(LINES_A);
            frame_id    <= '0;
            overrun_cnt <= '0;
            pending     <= 1'b0;
            last_mode   <= MODE_FIXED;
            alt_b       <= 1'b0;
        end else begin
            new_frame <= issue;
            if (!active) begin
                pending <= 1'b0;
            end else if (busy) begin
                if (tick) begin
                    if (pending) begin
                        if (overrun_cnt != '1)
                            overrun_cnt <= overrun_cnt + 1'b1;
                    end else begin
                        pending <= 1'b1;
                    end
                end
            end else begin
                // A tick landing on the drain cycle re-arms the slot for itself
                pending <= pending && tick;
            end
            if (issue) begin
                frame_lines <= next_lines;
                frame_id    <= frame_id + 1'b1;
                last_mode   <= cur_mode;
                if (cur_mode == MODE_ALT)
                    alt_b <= restart ? 1'b1 : !alt_b;
            end
        end
    end

endmodule

// File: tb/tb_i2c_diag_frame_gen.sv
// Scoreboard bench for i2c_diag_frame_gen: a cycle-level behavioural model
// pushes expected events; a negedge monitor pops and compares them.
module tb_i2c_diag_frame_gen;

    localparam int unsigned P = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       busy = 1'b0;
    logic       new_frame;
    logic [9:0] frame_lines;
    logic [7:0] frame_id;
    logic [7:0] overrun_cnt;
    logic       pending;

    i2c_diag_frame_gen #(
        .CLK_HZ    (1000),
        .PERIOD_MS (10),
        .LINES_A   (240),
        .LINES_B   (288),
        .LINES_MIN (200),
        .LINES_MAX (220),
        .LINES_STEP(8),
        .CNT_W     (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .mode       (mode),
        .busy       (busy),
        .new_frame  (new_frame),
        .frame_lines(frame_lines),
        .frame_id   (frame_id),
        .overrun_cnt(overrun_cnt),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        int unsigned lines;
        int unsigned id;
    } ev_t;

    ev_t         q[$];
    int unsigned cyc = 0;
    int unsigned m_phase = 0;
    int unsigned m_ovr = 0;
    int unsigned m_lines = 240;
    int unsigned m_id = 0;
    int unsigned m_k = 0;
    int unsigned m_last_mode = 0;
    bit          m_pending = 0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sequence value by event index since the last restart.
    function automatic int unsigned pick(input int unsigned md, input bit rs);
        int unsigned v;
        if (rs) m_k = 0;
        case (md)
            1:       v = (m_k % 2 == 0) ? 240 : 288;
            2:       v = 200 + 8 * (m_k % 3);
            default: v = 240;
        endcase
        m_k++;
        return v;
    endfunction

    // Reference model, evaluated on the values present at each rising edge.
    always @(posedge clk) begin
        bit tick;
        bit issue;
        cyc++;
        if (!resetn) begin
            m_phase = 0; m_ovr = 0; m_lines = 240; m_id = 0; m_k = 0;
            m_last_mode = 0; m_pending = 0;
            q.delete();
        end else if (!enable) begin
            m_phase   = 0;
            m_pending = 0;
        end else begin
            tick    = (m_phase == P - 1);
            m_phase = (m_phase + 1) % P;
            if (mode == 2'd3) begin
                m_pending = 0;
            end else begin
                issue = !busy && (tick || m_pending);
                if (busy) begin
                    if (tick) begin
                        if (m_pending) begin
                            if (m_ovr < 255) m_ovr++;
                        end else begin
                            m_pending = 1;
                        end
                    end
                end else begin
                    m_pending = m_pending && tick;
                end
                if (issue) begin
                    m_lines     = pick(mode, mode != m_last_mode);
                    m_last_mode = mode;
                    m_id        = (m_id + 1) % 256;
                    q.push_back('{cyc, m_lines, m_id});
                end
            end
        end
    end

    // Monitor: compares held state every cycle and matches each strobe against the queue.
    always @(negedge clk) begin
        ev_t e;
        if (resetn) begin
            check("pending", pending, m_pending);
            check("overrun_cnt", overrun_cnt, m_ovr);
            check("lines_held", frame_lines, m_lines);
            check("id_held", frame_id, m_id);
            if (new_frame) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pulse: got new_frame=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_lines", frame_lines, e.lines);
                    check("event_id", frame_id, e.id);
                end
            end
            while (q.size() > 0 && q[0].cyc <= cyc && !new_frame) begin
                total++; bad++;
                $display("FAIL missing_pulse: got new_frame=0 expected 1 (cycle %0d)", q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    task automatic go(input bit en, input int unsigned md, input bit bz, input int unsigned n);
        enable = en;
        mode   = 2'(md);
        busy   = bz;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_new_frame", new_frame, 0);
        check("rst_lines", frame_lines, 240);
        check("rst_id", frame_id, 0);
        check("rst_overrun", overrun_cnt, 0);
        check("rst_pending", pending, 0);
    endtask

    initial begin
        int unsigned ov;
        int unsigned i;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values();
        resetn = 1'b1;

        // fixed mode, steady periodic events
        go(1, 0, 0, 35);
        // alternate, then restart via mode 0
        go(1, 1, 0, 40);
        go(1, 0, 0, 10);
        go(1, 1, 0, 20);
        // sweep with wrap
        go(1, 2, 0, 50);
        // back-pressure across three ticks, then release
        go(1, 0, 1, 30);
        go(1, 0, 0, 15);
        // overrun saturation
        go(1, 0, 1, 3000);
        check("overrun_saturated", overrun_cnt, 255);
        go(1, 0, 0, 15);

        // release busy on the exact tick cycle while an event is queued
        go(1, 0, 1, 1);
        for (i = 0; i < 30 && !m_pending; i++) go(1, 0, 1, 1);
        check("pending_armed", pending, 1);
        for (i = 0; i < 40 && m_phase != P - 1; i++) go(1, 0, 1, 1);
        ov = overrun_cnt;
        go(1, 0, 0, 6);
        check("no_overrun_on_drain_tick", overrun_cnt, ov);

        // asynchronous reset mid-period with an event queued
        go(1, 0, 1, 12);
        resetn = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        #1;
        resetn = 1'b1;
        go(1, 0, 0, 25);
        // enable drop clears queue and counter phase
        go(1, 0, 1, 12);
        go(0, 0, 0, 5);
        check("disable_pending", pending, 0);
        go(1, 0, 0, 25);
        // silent mode
        ov = overrun_cnt;
        go(1, 3, 0, 25);
        go(1, 3, 1, 25);
        check("silent_overrun", overrun_cnt, ov);

        // randomized segments
        for (int s = 0; s < 40; s++) begin
            if ($urandom % 15 == 0) begin
                resetn = 1'b0;
                repeat (2) @(negedge clk);
                #1;
                resetn = 1'b1;
            end
            go(($urandom % 8) != 0, $urandom % 4, ($urandom % 3) == 0, $urandom_range(5, 40));
        end

        go(1, 0, 0, 5);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
